// File: rtl/adc_deser_pkg.sv
// Shared types and helpers for the ADC deserializer frame-alignment block.
package adc_deser_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StCheck,
        StSlip,
        StLocked,
        StError
    } state_e;

    localparam int unsigned MAX_RES = 16;

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Reverses the low `width` bits of `word`. Bits above `width` return as zero.
    function automatic logic [MAX_RES-1:0] bit_reverse(input logic [MAX_RES-1:0] word,
                                                       input int unsigned width);
        logic [MAX_RES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_RES; i++) begin
            if (i < width) begin
                r[i] = word[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_deser_word_reg.sv
// One deserializer lane: registers the raw word, optionally bit-reversed so the
// first serial bit lands on the MSB.
module adc_deser_word_reg
    import adc_deser_pkg::*;
#(
    parameter int unsigned RES       = 12,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RES-1:0] d,
    output logic [RES-1:0] q
);

    logic [RES-1:0] ordered;

    always_comb begin
        ordered = d;
        if (MSB_FIRST) begin
            ordered = RES'(bit_reverse(MAX_RES'(d), RES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= ordered;
        end
    end

endmodule

// File: rtl/adc_deser_frame_align.sv
// CLKDIV-domain BITSLIP alignment controller and sample assembler for a
// frame lane plus N_CH data lanes of ISERDES deserializers.
module adc_deser_frame_align
    import adc_deser_pkg::*;
#(
    parameter int unsigned    N_CH          = 8,
    parameter int unsigned    RES           = 12,
    parameter logic [RES-1:0] FRAME_PATTERN = 12'hFC0,
    parameter int unsigned    SLIP_WAIT     = 3,
    parameter int unsigned    MATCH_CNT     = 8,
    parameter int unsigned    LOSS_CNT      = 4,
    parameter bit             MSB_FIRST     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      align_start,
    input  logic [RES-1:0]            frame_q,
    input  logic [N_CH*RES-1:0]       data_q,
    output logic                      bitslip,
    output logic [N_CH*RES-1:0]       data_out,
    output logic                      data_valid,
    output logic                      locked,
    output logic                      align_err,
    output logic [$clog2(RES+1)-1:0]  slip_count
);

    localparam int unsigned WAIT_W  = cnt_width(SLIP_WAIT);
    localparam int unsigned MATCH_W = cnt_width(MATCH_CNT);
    localparam int unsigned LOSS_W  = cnt_width(LOSS_CNT);
    localparam int unsigned SLIP_W  = $clog2(RES + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_CNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(MATCH_CNT);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CNT - 1);
    localparam logic [SLIP_W-1:0]  SLIP_LAST  = SLIP_W'(RES - 1);
    localparam logic [SLIP_W-1:0]  SLIP_FULL  = SLIP_W'(RES);

    logic [RES-1:0]      frame_ord;
    logic [N_CH*RES-1:0] data_ord;
    logic [N_CH*RES-1:0] data_out_q;
    logic                data_valid_q;
    logic                frame_match;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic                err_q, err_d;

    adc_deser_word_reg #(
        .RES       (RES),
        .MSB_FIRST (MSB_FIRST)
    ) u_frame_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (frame_q),
        .q     (frame_ord)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        adc_deser_word_reg #(
            .RES       (RES),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (data_q[k*RES +: RES]),
            .q     (data_ord[k*RES +: RES])
        );
    end

    assign frame_match = (frame_ord == FRAME_PATTERN);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        match_d = match_q;
        loss_d  = loss_q;
        slip_d  = slip_q;
        err_d   = err_q;

        // A start request overrides every state, including the slip cycle.
        if (align_start) begin
            state_d = StWait;
            wait_d  = '0;
            match_d = '0;
            loss_d  = '0;
            slip_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StWait: begin
                    if (wait_q >= WAIT_LAST) begin
                        state_d = StCheck;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                StCheck: begin
                    if (frame_match) begin
                        if (match_q >= MATCH_LAST) begin
                            state_d = StLocked;
                            match_d = MATCH_FULL;
                            loss_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                        if (slip_q < SLIP_LAST) begin
                            state_d = StSlip;
                        end else begin
                            state_d = StError;
                            err_d   = 1'b1;
                        end
                    end
                end
                StSlip: begin
                    state_d = StWait;
                    wait_d  = '0;
                    if (slip_q < SLIP_FULL) begin
                        slip_d = slip_q + SLIP_W'(1);
                    end
                end
                StLocked: begin
                    if (frame_match) begin
                        loss_d = '0;
                    end else if (loss_q >= LOSS_LAST) begin
                        // Lost lock: re-sweep from the current slip position.
                        state_d = StWait;
                        wait_d  = '0;
                        match_d = '0;
                        loss_d  = '0;
                        slip_d  = '0;
                    end else begin
                        loss_d = loss_q + LOSS_W'(1);
                    end
                end
                StError: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            match_q      <= '0;
            loss_q       <= '0;
            slip_q       <= '0;
            err_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            match_q      <= match_d;
            loss_q       <= loss_d;
            slip_q       <= slip_d;
            err_q        <= err_d;
            data_out_q   <= data_ord;
            data_valid_q <= (state_q == StLocked);
        end
    end

    assign bitslip    = (state_q == StSlip) && !align_start;
    assign locked     = (state_q == StLocked);
    assign align_err  = err_q;
    assign slip_count = slip_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_adc_deser_frame_align.sv
// Bench for adc_deser_frame_align: a rotating deserializer stub feeds random
// samples; a scoreboard compares DATA_OUT against the samples sent.
module tb_adc_deser_frame_align;

    localparam int unsigned N_CH      = 8;
    localparam int unsigned RES       = 12;
    localparam int unsigned SLIP_WAIT = 3;
    localparam int unsigned MATCH_CNT = 8;
    localparam int unsigned LOSS_CNT  = 4;
    localparam logic [11:0] PATTERN   = 12'hFC0;
    localparam int unsigned SW        = $clog2(RES + 1);

    typedef struct {
        int                  tag;
        logic [N_CH*RES-1:0] data;
    } exp_item_t;

    logic                clk;
    logic                rst_n;
    logic                align_start;
    logic [RES-1:0]      frame_q;
    logic [N_CH*RES-1:0] data_q;
    logic                bitslip;
    logic [N_CH*RES-1:0] data_out;
    logic                data_valid;
    logic                locked;
    logic                align_err;
    logic [SW-1:0]       slip_count;

    logic                l_align_start;
    logic                l_bitslip;
    logic [N_CH*RES-1:0] l_data_out;
    logic                l_data_valid;
    logic                l_locked;
    logic                l_align_err;
    logic [SW-1:0]       l_slip_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          offset  = 0;
    int          slips_seen = 0;
    int          last_slip  = -1;
    int          frame_mode = 0;  // 0 aligned stream, 1 stuck at zero, 2 corrupted
    bit          hold = 1'b0;
    logic [11:0] samples [N_CH];
    exp_item_t   exp_q [$];

    adc_deser_frame_align #(
        .N_CH          (N_CH),
        .RES           (RES),
        .FRAME_PATTERN (PATTERN),
        .SLIP_WAIT     (SLIP_WAIT),
        .MATCH_CNT     (MATCH_CNT),
        .LOSS_CNT      (LOSS_CNT),
        .MSB_FIRST     (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .align_start (align_start),
        .frame_q     (frame_q),
        .data_q      (data_q),
        .bitslip     (bitslip),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .locked      (locked),
        .align_err   (align_err),
        .slip_count  (slip_count)
    );

    adc_deser_frame_align #(
        .N_CH          (N_CH),
        .RES           (RES),
        .FRAME_PATTERN (PATTERN),
        .SLIP_WAIT     (SLIP_WAIT),
        .MATCH_CNT     (MATCH_CNT),
        .LOSS_CNT      (LOSS_CNT),
        .MSB_FIRST     (1'b0)
    ) u_dut_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .align_start (l_align_start),
        .frame_q     (frame_q),
        .data_q      (data_q),
        .bitslip     (l_bitslip),
        .data_out    (l_data_out),
        .data_valid  (l_data_valid),
        .locked      (l_locked),
        .align_err   (l_align_err),
        .slip_count  (l_slip_count)
    );

    function automatic logic [11:0] rev12(input logic [11:0] w);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = w[11-i];
        return r;
    endfunction

    function automatic logic [11:0] rotl12(input logic [11:0] w, input int n);
        logic [23:0] t;
        t = {w, w} << n;
        return t[23:12];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Deserializer stub: word position drifts by (offset - slips) mod RES.
    initial begin
        int                  mis;
        logic [N_CH*RES-1:0] packed_s;
        exp_item_t           e;
        frame_q = '0;
        data_q  = '0;
        for (int k = 0; k < N_CH; k++) samples[k] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mis = ((offset - slips_seen) % int'(RES) + int'(RES)) % int'(RES);
            if (!hold) begin
                for (int k = 0; k < N_CH; k++) samples[k] = 12'($urandom);
            end
            if (frame_mode == 1) frame_q = 12'h000;
            else if (frame_mode == 2) frame_q = rotl12(rev12(PATTERN), mis) ^ 12'h00F;
            else frame_q = rotl12(rev12(PATTERN), mis);
            for (int k = 0; k < N_CH; k++) begin
                packed_s[k*RES +: RES] = samples[k];
                data_q[k*RES +: RES]   = rotl12(rev12(samples[k]), mis);
            end
            e.tag  = cyc;
            e.data = packed_s;
            exp_q.push_back(e);
        end
    end

    // Monitor: counts slips seen by the stub and scores DATA_OUT (2-cycle latency).
    initial begin
        exp_item_t e;
        forever begin
            @(negedge clk);
            if (bitslip === 1'b1) begin
                slips_seen++;
                if (last_slip >= 0) begin
                    check("bitslip_spacing", 128'(cyc - last_slip >= int'(SLIP_WAIT + 2)), 128'(1));
                end
                last_slip = cyc;
            end
            while (exp_q.size() > 0 && exp_q[0].tag < cyc - 2) void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].tag == cyc - 2) begin
                e = exp_q.pop_front();
                if (rst_n && data_valid) check("data_out", data_out, e.data);
            end
        end
    end

    task automatic pulse_start(input int new_mis, input int fmode);
        @(posedge clk);
        #2 align_start = 1'b1;
        @(posedge clk);
        #2 align_start = 1'b0;
        if (new_mis >= 0) offset = slips_seen + new_mis;
        frame_mode = fmode;
    endtask

    task automatic wait_for_lock(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        repeat (budget) begin
            @(posedge clk);
            #2;
            n++;
            if (locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int n;
        bit ok;
        int s0;
        bit dropped;

        rst_n         = 1'b0;
        align_start   = 1'b0;
        l_align_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_locked", locked, 0);
        check("rst_valid", data_valid, 0);
        check("rst_err", align_err, 0);
        check("rst_bitslip", bitslip, 0);
        check("rst_slip_count", slip_count, 0);
        check("rst_data_out", data_out, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("idle_locked", locked, 0);

        // Offset 0: lock without any slip.
        s0 = slips_seen;
        pulse_start(-1, 0);
        wait_for_lock(200, n, ok);
        check("lock_off0", ok, 1);
        check("lock_latency_off0", n + 1, SLIP_WAIT + MATCH_CNT + 1);
        check("slips_off0", slips_seen - s0, 0);
        check("slip_count_off0", slip_count, 0);
        @(posedge clk);
        #2 check("valid_after_lock", data_valid, 1);
        repeat (30) @(posedge clk);

        // Offset 5: exactly five slips.
        s0 = slips_seen;
        pulse_start(5, 0);
        wait_for_lock(400, n, ok);
        check("lock_off5", ok, 1);
        check("slips_off5", slips_seen - s0, 5);
        check("slip_count_off5", slip_count, 5);
        #1 hold = 1'b1;
        samples[3] = 12'h5A3;
        repeat (4) @(posedge clk);
        #2 check("lane3_5a3", data_out[3*RES +: RES], 12'h5A3);
        hold = 1'b0;
        repeat (20) @(posedge clk);

        // Stuck frame: full sweep fails.
        s0 = slips_seen;
        pulse_start(-1, 1);
        ok = 1'b0;
        repeat (400) begin
            @(posedge clk);
            #2;
            if (align_err) begin
                ok = 1'b1;
                break;
            end
        end
        check("err_reached", ok, 1);
        check("slips_stuck", slips_seen - s0, RES - 1);
        check("slip_count_stuck", slip_count, RES - 1);
        check("locked_in_err", locked, 0);
        repeat (5) @(posedge clk);
        #2 check("err_sticky", align_err, 1);
        pulse_start(-1, 0);
        check("err_cleared", align_err, 0);
        wait_for_lock(400, n, ok);
        check("relock_after_err", ok, 1);
        repeat (10) @(posedge clk);

        // Three corrupt frames: lock holds.
        #2 frame_mode = 2;
        repeat (3) @(posedge clk);
        #2 frame_mode = 0;
        dropped = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (!locked) dropped = 1'b1;
        end
        check("loss3_keeps_lock", dropped, 0);

        // Four corrupt frames: lock drops, then re-sweeps on its own.
        s0 = slips_seen;
        frame_mode = 2;
        repeat (4) @(posedge clk);
        #2 frame_mode = 0;
        dropped = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (!locked) begin
                dropped = 1'b1;
                break;
            end
        end
        check("loss4_drops_lock", dropped, 1);
        wait_for_lock(200, n, ok);
        check("auto_relock", ok, 1);
        check("auto_relock_slips", slips_seen - s0, 0);
        check("auto_relock_slip_count", slip_count, 0);
        repeat (10) @(posedge clk);

        // Reset during a slip cycle.
        pulse_start(6, 0);
        ok = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #2;
            if (bitslip) begin
                ok = 1'b1;
                break;
            end
        end
        check("slip_seen_before_rst", ok, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bitslip", bitslip, 0);
        check("rst_mid_locked", locked, 0);
        check("rst_mid_valid", data_valid, 0);
        check("rst_mid_slip_count", slip_count, 0);
        check("rst_mid_data_out", data_out, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        pulse_start(-1, 0);
        wait_for_lock(400, n, ok);
        check("relock_after_rst", ok, 1);
        check("err_after_rst", align_err, 0);

        // Bit ordering: raw word 12'h001 on lane 0.
        #1 hold = 1'b1;
        samples[0] = 12'h800;
        repeat (4) @(posedge clk);
        #2;
        check("msb_first_1", data_out[RES-1:0], 12'h800);
        check("msb_first_0", l_data_out[RES-1:0], 12'h001);
        hold = 1'b0;
        repeat (20) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
